// File: rtl/seq_alu_if.sv
// Execute-stage port bundle for seq_alu: operand handshake in, result handshake out.
// The master drives operands and OutReady; the slave (seq_alu) drives InReady, OutValid, Result and Busy.
interface seq_alu_if #(
    parameter int WIDTH = 64
);
    logic             Flush;
    logic             InValid;
    logic             InReady;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       Op;
    logic             W64;
    logic             OutValid;
    logic             OutReady;
    logic [WIDTH-1:0] Result;
    logic             Busy;

    modport master (
        output Flush, InValid, A, B, Op, W64, OutReady,
        input  InReady, OutValid, Result, Busy
    );

    modport slave (
        input  Flush, InValid, A, B, Op, W64, OutReady,
        output InReady, OutValid, Result, Busy
    );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle integer ALU for the IEU execute stage.
// Single-cycle integer ops plus iterative carry-less multiply, consuming STEP multiplier bits per cycle.
module seq_alu #(
    parameter int WIDTH = 64,
    parameter int STEP  = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    seq_alu_if.slave   bus,
    output logic [1:0] dbg_state
);

    localparam int N   = WIDTH / STEP;
    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = $clog2(N) + 1;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    localparam logic [3:0] OP_ADD    = 4'd0;
    localparam logic [3:0] OP_SUB    = 4'd1;
    localparam logic [3:0] OP_SLT    = 4'd2;
    localparam logic [3:0] OP_SLTU   = 4'd3;
    localparam logic [3:0] OP_XOR    = 4'd4;
    localparam logic [3:0] OP_OR     = 4'd5;
    localparam logic [3:0] OP_AND    = 4'd6;
    localparam logic [3:0] OP_SLL    = 4'd7;
    localparam logic [3:0] OP_SRL    = 4'd8;
    localparam logic [3:0] OP_SRA    = 4'd9;
    localparam logic [3:0] OP_CLMUL  = 4'd10;
    localparam logic [3:0] OP_CLMULH = 4'd11;
    localparam logic [3:0] OP_CLMULR = 4'd12;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [2*WIDTH-1:0] a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [3:0]         op_reg;
    logic [2*WIDTH-1:0] p;
    logic [2*WIDTH-1:0] p_step;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   result;
    logic [WIDTH-1:0]   alu_out;
    logic [WIDTH-1:0]   clmul_out;

    logic in_ready;
    logic accept;
    logic is_clmul;
    logic last_step;

    function automatic logic [WIDTH-1:0] sext32(input logic [31:0] x);
        logic [WIDTH-1:0] r;
        r       = {WIDTH{x[31]}};
        r[31:0] = x;
        return r;
    endfunction

    // Handshake: a transfer happens on any edge where valid & ready are both high.
    // InValid/operands are taken when InReady=1; Result stays put while OutValid & ~OutReady.
    // Flush forces InReady low so nothing is accepted in the cycle it is asserted.
    assign in_ready  = ~bus.Flush & ((state == S_IDLE) | ((state == S_DONE) & bus.OutReady));
    assign accept    = bus.InValid & in_ready;
    assign is_clmul  = (bus.Op == OP_CLMUL) || (bus.Op == OP_CLMULH) || (bus.Op == OP_CLMULR);
    assign last_step = (state == S_BUSY) && (cnt == CW'(N - 1));

    assign bus.InReady  = in_ready;
    assign bus.OutValid = (state == S_DONE);
    assign bus.Busy     = (state == S_BUSY);
    assign bus.Result   = result;
    assign dbg_state    = state;

    // Single-cycle datapath; word forms compute on the low 32 bits and sign-extend.
    always_comb begin
        logic [31:0]    a32;
        logic [31:0]    b32;
        logic [31:0]    r32;
        logic [4:0]     sh32;
        logic [SHW-1:0] shamt;
        logic           word_op;
        a32     = bus.A[31:0];
        b32     = bus.B[31:0];
        sh32    = bus.B[4:0];
        shamt   = bus.B[SHW-1:0];
        r32     = '0;
        word_op = 1'b0;
        alu_out = '0;
        case (bus.Op)
            OP_ADD: begin
                r32     = a32 + b32;
                alu_out = bus.A + bus.B;
                word_op = 1'b1;
            end
            OP_SUB: begin
                r32     = a32 + ~b32 + 32'd1;
                alu_out = bus.A + ~bus.B + ONE;
                word_op = 1'b1;
            end
            OP_SLT:  alu_out = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
            OP_SLTU: alu_out = {{(WIDTH-1){1'b0}}, (bus.A < bus.B)};
            OP_XOR:  alu_out = bus.A ^ bus.B;
            OP_OR:   alu_out = bus.A | bus.B;
            OP_AND:  alu_out = bus.A & bus.B;
            OP_SLL: begin
                r32     = a32 << sh32;
                alu_out = bus.A << shamt;
                word_op = 1'b1;
            end
            OP_SRL: begin
                r32     = a32 >> sh32;
                alu_out = bus.A >> shamt;
                word_op = 1'b1;
            end
            OP_SRA: begin
                r32     = $unsigned($signed(a32) >>> sh32);
                alu_out = $unsigned($signed(bus.A) >>> shamt);
                word_op = 1'b1;
            end
            default: alu_out = '0;
        endcase
        if ((WIDTH == 64) && bus.W64 && word_op) begin
            alu_out = sext32(r32);
        end
    end

    // One CLMUL iteration: a_sh/b_sh are pre-shifted so bit j of b_sh weights a_sh << j.
    always_comb begin
        p_step = p;
        for (int j = 0; j < STEP; j++) begin
            if (b_sh[j]) begin
                p_step = p_step ^ (a_sh << j);
            end
        end
    end

    always_comb begin
        case (op_reg)
            OP_CLMULH: clmul_out = p_step[2*WIDTH-1:WIDTH];
            OP_CLMULR: clmul_out = p_step[2*WIDTH-2:WIDTH-1];
            default:   clmul_out = p_step[WIDTH-1:0];
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (bus.Flush) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) state_next = is_clmul ? S_BUSY : S_DONE;
                end
                S_BUSY: begin
                    if (last_step) state_next = S_DONE;
                end
                S_DONE: begin
                    if (accept)            state_next = is_clmul ? S_BUSY : S_DONE;
                    else if (bus.OutReady) state_next = S_IDLE;
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    // Result only changes on a single-cycle accept or the final CLMUL step, so a flushed
    // or reset multiply never exposes a partial product.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            op_reg <= '0;
            p      <= '0;
            cnt    <= '0;
            result <= '0;
        end else if (bus.Flush) begin
            cnt <= '0;
        end else if (accept) begin
            if (is_clmul) begin
                a_sh   <= {{WIDTH{1'b0}}, bus.A};
                b_sh   <= bus.B;
                op_reg <= bus.Op;
                p      <= '0;
                cnt    <= '0;
            end else begin
                result <= alu_out;
            end
        end else if (state == S_BUSY) begin
            p    <= p_step;
            a_sh <= a_sh << STEP;
            b_sh <= b_sh >> STEP;
            cnt  <= cnt + CW'(1);
            if (last_step) begin
                result <= clmul_out;
                cnt    <= '0;
            end
        end
    end

endmodule
